mem_block_copier: RTL and testbench
===================================

MEM_BLOCK_COPIER -- requirements
Module: mem_block_copier

Interface
REQ-001 Parameter MEM_BYTES, default 128, meaning size in bytes of the attached byte-addressed data memory.
REQ-002 Parameter CNT_W, default 8, meaning width of the word-count input.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  request a copy; sampled only while in IDLE.
REQ-006 SrcAddr  input  24  byte address of the first source word.
REQ-007 DstAddr  input  24  byte address of the first destination word.
REQ-008 WordCount  input  CNT_W  number of 24-bit words to copy.
REQ-009 Busy  output  1  high while a copy is in progress (READ, WRITE, DONE states).
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 Error  output  1  range-violation flag; valid while Done=1, held until the next accepted Start.
REQ-012 Address  output  24  byte address driven to the data memory.
REQ-013 WriteData  output  24  big-endian word to memory: [23:16] at Address, [15:8] at Address+1, [7:0] at Address+2.
REQ-014 MemWrite  output  1  memory write strobe; the memory commits on the rising edge while it is high.
REQ-015 MemRead  output  1  memory read strobe.
REQ-016 ReadData  input  24  combinational read data for the current Address, big-endian.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE and DONE.
REQ-018 IDLE with Start=1 at an edge SHALL latch SrcAddr, DstAddr and WordCount into internal source, destination and remaining registers, and clear Error.
- On that same edge, if any check fails the FSM SHALL go to DONE with Error=1.
- Otherwise, if WordCount=0 the FSM SHALL go to DONE with Error=0.
- Otherwise the FSM SHALL go to READ.
REQ-019 Range check SHALL be computed in at least 26-bit unsigned arithmetic with no wrap: a failure is SrcAddr+3*WordCount > MEM_BYTES or DstAddr+3*WordCount > MEM_BYTES, and it applies only when WordCount≠0.
REQ-020 READ SHALL drive MemRead=1, MemWrite=0 and Address=source register, capture ReadData into a 24-bit hold register at the edge, then go to WRITE.
REQ-021 WRITE SHALL drive MemWrite=1, MemRead=0, Address=destination register and WriteData=hold register.
- At the edge the source and destination registers SHALL each increment by 3 and the remaining register SHALL decrement by 1.
- The FSM SHALL go to DONE if remaining was 1, else to READ.
REQ-022 DONE SHALL assert Done=1 for exactly one cycle, then return to IDLE.
REQ-023 Latency: for N≥1 words with a passing range check, Done SHALL be high in cycle 2N+1 after the Start edge, and exactly N memory writes SHALL occur.
REQ-024 For N=0 or a range error, Done SHALL be high in the cycle immediately after the Start edge, with no MemRead or MemWrite asserted.
REQ-025 Start while not in IDLE SHALL be ignored, and input changes after acceptance SHALL have no effect.
REQ-026 The copy SHALL be strictly forward and word-sequential; overlapping regions SHALL yield exactly the result of that sequential order.
REQ-027 MemRead and MemWrite SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and DONE.
REQ-028 In IDLE and DONE, Address and WriteData SHALL be 0.

Reset
REQ-029 Reset=1 SHALL immediately force IDLE and set Busy, Done, Error, MemRead, MemWrite, Address and WriteData to 0, independent of Clock.
REQ-030 Reset asserted during WRITE SHALL deassert MemWrite before the next edge, so no partial or further memory write occurs.
REQ-031 Internal registers (source, destination, remaining, hold) SHALL reset to 0.

Structure
REQ-032 The shared package mem_pkg SHALL hold the constants WORD_BYTES=3, ADDR_W=24, DATA_W=24 and MEM_BYTES default, plus the FSM state encoding.
REQ-033 The range check SHALL be a sub-module mem_range_check with inputs base address and count, and an output in_range; it is instantiated twice, once for source and once for destination.

Verification
REQ-034 Src=0, Dst=30, N=2, memory[0..5]=01..06: Done in cycle 5; memory[30..35]=01..06; Error=0.
REQ-035 Src=10, N=0: Done in cycle 1; no strobes asserted; Error=0.
REQ-036 Src=120, Dst=0, N=3 (end 129>128): Done in cycle 1; Error=1; memory unchanged.
REQ-037 Overlap Src=0, Dst=3, N=2, memory[0..2]=AA,BB,CC: memory[3..8]=AA,BB,CC,AA,BB,CC.
REQ-038 Reset pulsed during the second WRITE of an N=4 copy: outputs go to 0 immediately; only the first word is written; a new Start then completes normally.
REQ-039 Start held high through an N=3 copy: exactly one Done pulse per accepted Start, with Done/Busy re-accept timing exactly per REQ-022/REQ-023.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the block copier.
package mem_pkg;
    localparam int WORD_BYTES    = 3;
    localparam int ADDR_W        = 24;
    localparam int DATA_W        = 24;
    localparam int MEM_BYTES_DEF = 128;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/mem_range_check.sv
// Checks that a block of 'count' words starting at 'base' lies inside memory.
// Arithmetic is widened so base + 3*count can never wrap.
module mem_range_check
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int CNT_W     = 8
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    output logic              in_range
);
    // Wide enough for the full 24-bit base plus 3x the largest count.
    localparam int EXT_W = (ADDR_W + CNT_W + 2 > 26) ? (ADDR_W + CNT_W + 2) : 26;

    logic [EXT_W-1:0] end_addr;

    // One past the last byte touched; a zero-length block is always in range.
    always_comb begin
        end_addr = EXT_W'(base) + EXT_W'(count) * EXT_W'(WORD_BYTES);
        in_range = (count == '0) || (end_addr <= EXT_W'(MEM_BYTES));
    end
endmodule

// File: rtl/mem_block_copier.sv
// Word-by-word forward memory copier: READ a 24-bit word, WRITE it, repeat.
// Strobes and address are decoded straight from the state so an async reset
// drops them within the same cycle.
module mem_block_copier
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int CNT_W     = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [CNT_W-1:0]  WordCount,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] ReadData
);
    logic [1:0]        state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] hold;
    logic              error_q;
    logic              src_ok;
    logic              dst_ok;

    mem_range_check #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) u_src_check (
        .base     (SrcAddr),
        .count    (WordCount),
        .in_range (src_ok)
    );

    mem_range_check #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) u_dst_check (
        .base     (DstAddr),
        .count    (WordCount),
        .in_range (dst_ok)
    );

    // Sequencer: accept a request, then alternate READ/WRITE until the count runs out.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            hold      <= '0;
            error_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        src       <= SrcAddr;
                        dst       <= DstAddr;
                        remaining <= WordCount;
                        if (!(src_ok && dst_ok)) begin
                            error_q <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            error_q <= 1'b0;
                            state   <= (WordCount == '0) ? ST_DONE : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    hold  <= ReadData;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    src       <= src + ADDR_W'(WORD_BYTES);
                    dst       <= dst + ADDR_W'(WORD_BYTES);
                    remaining <= remaining - 1'b1;
                    state     <= (remaining == CNT_W'(1)) ? ST_DONE : ST_READ;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs are pure state decodes; idle/done park everything at zero.
    always_comb begin
        Busy      = (state != ST_IDLE);
        Done      = (state == ST_DONE);
        MemRead   = (state == ST_READ);
        MemWrite  = (state == ST_WRITE);
        Address   = '0;
        WriteData = '0;
        case (state)
            ST_READ:  Address = src;
            ST_WRITE: begin
                Address   = dst;
                WriteData = hold;
            end
            default: begin
                Address   = '0;
                WriteData = '0;
            end
        endcase
        Error = error_q;
    end
endmodule

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier with a behavioural byte memory.
module tb_mem_block_copier;
    localparam int MB = 128;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [23:0] SrcAddr;
    logic [23:0] DstAddr;
    logic [7:0]  WordCount;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [23:0] Address;
    logic [23:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [23:0] ReadData;

    logic [7:0] mem [MB];

    int n_checks = 0;
    int n_fail   = 0;

    mem_block_copier #(.MEM_BYTES(MB), .CNT_W(8)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .SrcAddr   (SrcAddr),
        .DstAddr   (DstAddr),
        .WordCount (WordCount),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData)
    );

    always #5 Clock = ~Clock;

    // Big-endian combinational read port.
    always_comb begin
        ReadData = '0;
        if (int'(Address) + 2 < MB)
            ReadData = {mem[int'(Address)], mem[int'(Address) + 1], mem[int'(Address) + 2]};
    end

    // Memory commits on the rising edge while MemWrite is high.
    always @(posedge Clock) begin
        if (MemWrite && (int'(Address) + 2 < MB)) begin
            mem[int'(Address)]     = WriteData[23:16];
            mem[int'(Address) + 1] = WriteData[15:8];
            mem[int'(Address) + 2] = WriteData[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Issue one Start, scramble inputs afterwards, and track Done timing and strobes.
    task automatic run_copy(input logic [23:0] s, input logic [23:0] d, input logic [7:0] n,
                            output int done_cyc, output int writes, output int reads,
                            output int overlap, output logic err);
        done_cyc = -1; writes = 0; reads = 0; overlap = 0; err = 1'bx;
        SrcAddr = s; DstAddr = d; WordCount = n; Start = 1'b1;
        tick();
        Start = 1'b0;
        SrcAddr = 24'(($urandom % 40) + 24'h55); DstAddr = 24'h7; WordCount = 8'd9;
        for (int c = 1; c <= 60; c++) begin
            if (MemWrite) writes++;
            if (MemRead) reads++;
            if (MemRead && MemWrite) overlap++;
            if (Done) begin
                done_cyc = c;
                err = Error;
                break;
            end
            tick();
        end
        tick();
    endtask

    int dc, wr, rd, ov, dones;
    logic er;

    initial begin
        Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; WordCount = '0;
        for (int i = 0; i < MB; i++) mem[i] = 8'h00;
        #2;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_error", 32'(Error), 32'd0);
        chk("reset_strobes", 32'({MemRead, MemWrite}), 32'd0);
        chk("reset_addr", 32'(Address), 32'd0);
        chk("reset_wdata", 32'(WriteData), 32'd0);
        tick();
        Reset = 1'b0;
        tick();

        // Basic copy of two words.
        for (int i = 0; i < 6; i++) mem[i] = 8'(i + 1);
        run_copy(24'd0, 24'd30, 8'd2, dc, wr, rd, ov, er);
        chk("t1_done_cycle", 32'(dc), 32'd5);
        chk("t1_writes", 32'(wr), 32'd2);
        chk("t1_overlap", 32'(ov), 32'd0);
        chk("t1_error", 32'(er), 32'd0);
        chk("t1_dst_lo", {8'h0, mem[30], mem[31], mem[32]}, 32'h010203);
        chk("t1_dst_hi", {8'h0, mem[33], mem[34], mem[35]}, 32'h040506);
        chk("t1_idle_addr", 32'(Address), 32'd0);

        // Zero-length request.
        run_copy(24'd10, 24'd0, 8'd0, dc, wr, rd, ov, er);
        chk("t2_done_cycle", 32'(dc), 32'd1);
        chk("t2_strobes", 32'(wr + rd), 32'd0);
        chk("t2_error", 32'(er), 32'd0);

        // Source overruns memory end (120 + 9 = 129 > 128).
        run_copy(24'd120, 24'd0, 8'd3, dc, wr, rd, ov, er);
        chk("t3_done_cycle", 32'(dc), 32'd1);
        chk("t3_strobes", 32'(wr + rd), 32'd0);
        chk("t3_error", 32'(er), 32'd1);
        chk("t3_error_held", 32'(Error), 32'd1);
        chk("t3_mem_unchanged", {8'h0, mem[0], mem[1], mem[2]}, 32'h010203);

        // Exactly at the end boundary (119 + 9 = 128) passes; clears Error.
        run_copy(24'd119, 24'd0, 8'd3, dc, wr, rd, ov, er);
        chk("t3b_done_cycle", 32'(dc), 32'd7);
        chk("t3b_error", 32'(er), 32'd0);

        // Destination overruns while source is fine.
        run_copy(24'd0, 24'd126, 8'd1, dc, wr, rd, ov, er);
        chk("t3c_error", 32'(er), 32'd1);
        chk("t3c_done_cycle", 32'(dc), 32'd1);

        // Overlapping forward copy replicates the first word.
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC;
        run_copy(24'd0, 24'd3, 8'd2, dc, wr, rd, ov, er);
        chk("t4_w0", {8'h0, mem[3], mem[4], mem[5]}, 32'hAABBCC);
        chk("t4_w1", {8'h0, mem[6], mem[7], mem[8]}, 32'hAABBCC);
        chk("t4_done_cycle", 32'(dc), 32'd5);

        // Reset during the second WRITE of a four-word copy.
        for (int i = 0; i < 12; i++) mem[i] = 8'(8'h10 + i);
        for (int i = 60; i < 72; i++) mem[i] = 8'h00;
        SrcAddr = 24'd0; DstAddr = 24'd60; WordCount = 8'd4; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        chk("t5_in_write2", 32'({MemWrite, Address}), {7'd0, 1'b1, 24'd63});
        Reset = 1'b1;
        #1;
        chk("t5_rst_strobe", 32'(MemWrite), 32'd0);
        chk("t5_rst_busy", 32'(Busy), 32'd0);
        chk("t5_rst_addr", 32'(Address), 32'd0);
        chk("t5_rst_wdata", 32'(WriteData), 32'd0);
        tick();
        Reset = 1'b0;
        chk("t5_word0", {8'h0, mem[60], mem[61], mem[62]}, 32'h101112);
        chk("t5_word1", {8'h0, mem[63], mem[64], mem[65]}, 32'h000000);
        run_copy(24'd0, 24'd90, 8'd1, dc, wr, rd, ov, er);
        chk("t5_restart_done", 32'(dc), 32'd3);
        chk("t5_restart_data", {8'h0, mem[90], mem[91], mem[92]}, 32'h101112);

        // Start held high: one Done per acceptance, re-accept after one IDLE cycle.
        SrcAddr = 24'd0; DstAddr = 24'd100; WordCount = 8'd3; Start = 1'b1;
        tick();
        dones = 0;
        for (int c = 1; c <= 7; c++) begin
            if (Done) dones++;
            if (c == 7) chk("t6_done_c7", 32'(Done), 32'd1);
            if (c < 7) tick();
        end
        chk("t6_one_done", 32'(dones), 32'd1);
        tick();
        chk("t6_idle_gap", 32'({Busy, Done}), 32'd0);
        tick();
        chk("t6_reaccept", 32'({Busy, MemRead}), 32'd3);
        Start = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (Done) dones++;
            tick();
        end
        chk("t6_second_done", 32'(dones), 32'd1);
        chk("t6_data", {8'h0, mem[106], mem[107], mem[108]}, {8'h0, mem[6], mem[7], mem[8]});
        chk("t6_data_abs", {8'h0, mem[100], mem[101], mem[102]}, 32'h101112);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
